// File: rtl/alu_exec_seq.sv
// alu_exec_seq: serialised execute-stage sequencer in front of the 16-bit ALU.
// Reads operands, drives the ALU, writes the result back and keeps the PSR.
module alu_exec_seq #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [4:0]         op_code,
    input  logic [REGBITS-1:0] op_rdest,
    input  logic [REGBITS-1:0] op_rsrc,
    input  logic               op_imm_sel,
    input  logic [WIDTH-1:0]   op_imm,
    input  logic               op_wb_en,
    input  logic               op_setflags,
    output logic               op_done,
    output logic               op_illegal,
    output logic [REGBITS-1:0] rf_raddr_a,
    output logic [REGBITS-1:0] rf_raddr_b,
    input  logic [WIDTH-1:0]   rf_rdata_a,
    input  logic [WIDTH-1:0]   rf_rdata_b,
    output logic               rf_we,
    output logic [REGBITS-1:0] rf_waddr,
    output logic [WIDTH-1:0]   rf_wdata,
    output logic [WIDTH-1:0]   alu_reg1,
    output logic [WIDTH-1:0]   alu_reg2,
    output logic [4:0]         alu_inst,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [WIDTH-1:0]   alu_flags,
    output logic [4:0]         psr
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t state;
    state_t state_nx;

    logic [4:0]         code_q;
    logic [REGBITS-1:0] rdest_q;
    logic [REGBITS-1:0] rsrc_q;
    logic               imm_sel_q;
    logic [WIDTH-1:0]   imm_q;
    logic               wb_en_q;
    logic               setflags_q;

    logic [WIDTH-1:0]   res_q;
    logic [4:0]         flg_q;
    logic [4:0]         psr_q;
    logic               illegal_q;
    logic [REGBITS-1:0] raddr_a_q;
    logic [REGBITS-1:0] raddr_b_q;
    logic [WIDTH-1:0]   reg1_q;
    logic [WIDTH-1:0]   reg2_q;
    logic [4:0]         inst_q;

    logic               xfer;
    logic               bad_op;
    logic               in_exec;
    logic [WIDTH-1:0]   opnd2;
    logic               unused_flags;

    assign xfer    = op_valid && (state == IDLE);
    assign bad_op  = op_code[2:0] > 3'b011;
    assign in_exec = (state == EXEC);
    assign opnd2   = imm_sel_q ? imm_q : rf_rdata_b;

    // ALU inputs follow the operands in EXEC and hold their value otherwise
    assign alu_reg1 = in_exec ? rf_rdata_a : reg1_q;
    assign alu_reg2 = in_exec ? opnd2 : reg2_q;
    assign alu_inst = in_exec ? code_q : inst_q;

    assign rf_raddr_a   = raddr_a_q;
    assign rf_raddr_b   = raddr_b_q;
    assign rf_waddr     = rdest_q;
    assign rf_wdata     = res_q;
    assign op_illegal   = illegal_q;
    assign psr          = psr_q;
    assign unused_flags = ^alu_flags[WIDTH-1:5];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        state_nx = state;
        op_ready = 1'b0;
        op_done  = 1'b0;
        rf_we    = 1'b0;
        unique case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid && !bad_op) begin
                    state_nx = READ;
                end
            end
            READ: state_nx = EXEC;
            EXEC: state_nx = WB;
            WB: begin
                op_done  = 1'b1;
                rf_we    = wb_en_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the operation on transfer; illegal ops pulse and are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q     <= '0;
            rdest_q    <= '0;
            rsrc_q     <= '0;
            imm_sel_q  <= 1'b0;
            imm_q      <= '0;
            wb_en_q    <= 1'b0;
            setflags_q <= 1'b0;
            illegal_q  <= 1'b0;
            raddr_a_q  <= '0;
            raddr_b_q  <= '0;
        end else begin
            illegal_q <= xfer && bad_op;
            if (xfer) begin
                code_q     <= op_code;
                rdest_q    <= op_rdest;
                rsrc_q     <= op_rsrc;
                imm_sel_q  <= op_imm_sel;
                imm_q      <= op_imm;
                wb_en_q    <= op_wb_en;
                setflags_q <= op_setflags;
            end
            if (xfer && !bad_op) begin
                raddr_a_q <= op_rdest;
                raddr_b_q <= op_rsrc;
            end
        end
    end

    // Capture ALU outputs and operands at the end of EXEC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q  <= '0;
            flg_q  <= '0;
            reg1_q <= '0;
            reg2_q <= '0;
            inst_q <= '0;
        end else if (in_exec) begin
            res_q  <= alu_result;
            flg_q  <= alu_flags[4:0];
            reg1_q <= rf_rdata_a;
            reg2_q <= opnd2;
            inst_q <= code_q;
        end
    end

    // PSR takes all five captured flags when the op asks for it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr_q <= '0;
        end else if (state == WB && setflags_q) begin
            psr_q <= flg_q;
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed bench with a latency-schedule model of the sequencer,
// a behavioural register file and a behavioural ALU around the DUT.
module tb_alu_exec_seq;

    localparam int W  = 16;
    localparam int RB = 4;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          op_valid = 1'b0;
    logic [4:0]    op_code = '0;
    logic [RB-1:0] op_rdest = '0;
    logic [RB-1:0] op_rsrc = '0;
    logic          op_imm_sel = 1'b0;
    logic [W-1:0]  op_imm = '0;
    logic          op_wb_en = 1'b0;
    logic          op_setflags = 1'b0;

    logic          op_ready;
    logic          op_done;
    logic          op_illegal;
    logic [RB-1:0] rf_raddr_a;
    logic [RB-1:0] rf_raddr_b;
    logic [W-1:0]  rf_rdata_a = '0;
    logic [W-1:0]  rf_rdata_b = '0;
    logic          rf_we;
    logic [RB-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  alu_reg1;
    logic [W-1:0]  alu_reg2;
    logic [4:0]    alu_inst;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  alu_flags;
    logic [4:0]    flg5;
    logic [4:0]    psr;

    int chk_cnt = 0;
    int pass_cnt = 0;

    alu_exec_seq #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rdest(op_rdest), .op_rsrc(op_rsrc),
        .op_imm_sel(op_imm_sel), .op_imm(op_imm),
        .op_wb_en(op_wb_en), .op_setflags(op_setflags),
        .op_done(op_done), .op_illegal(op_illegal),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_inst(alu_inst),
        .alu_result(alu_result), .alu_flags(alu_flags), .psr(psr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: flags {N,E,O,L,C}, unused flags cleared per class
    function automatic void alu_f(input logic [15:0] a, input logic [15:0] b,
                                  input logic [4:0] inst,
                                  output logic [15:0] r, output logic [4:0] f);
        logic [16:0] s;
        r = '0;
        f = '0;
        s = inst[4] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        case (inst[2:0])
            3'd0: begin
                r = s[15:0];
                f[3] = (r == 16'h0);
                if (inst[3]) begin
                    f[4] = r[15];
                    f[2] = inst[4] ? (a[15] != b[15] && r[15] != a[15])
                                   : (a[15] == b[15] && r[15] != a[15]);
                end else begin
                    f[1] = (a > b);
                    f[0] = s[16];
                end
            end
            3'd1: begin r = a & b; f[3] = (r == 16'h0); end
            3'd2: begin r = a | b; f[3] = (r == 16'h0); end
            3'd3: begin r = a ^ b; f[3] = (r == 16'h0); end
            default: r = '0;
        endcase
    endfunction

    always_comb begin
        alu_result = '0;
        flg5 = '0;
        alu_f(alu_reg1, alu_reg2, alu_inst, alu_result, flg5);
    end
    assign alu_flags = {11'h0, flg5};

    // Register file environment: synchronous read, plus a bench preload port
    logic [W-1:0]  rf [16] = '{default: '0};
    logic          pre_we = 1'b0;
    logic [RB-1:0] pre_idx = '0;
    logic [W-1:0]  pre_val = '0;

    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (pre_we) rf[pre_idx] <= pre_val;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // Model: a per-cycle schedule of expected events, indexed by edge count
    int          cyc = 0;
    int          free_at = 0;
    bit          e_we [N];
    bit          e_done [N];
    bit          e_ill [N];
    bit          e_ps [N];
    logic [3:0]  e_wa [N];
    logic [15:0] e_wd [N];
    logic [4:0]  e_pv [N];
    logic [15:0] m_rf [16] = '{default: '0};
    logic [4:0]  m_psr = '0;
    logic [15:0] ma, mb, mr;
    logic [4:0]  mf;
    int          hs [$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset_n && op_valid && op_ready) hs.push_back(cyc);
        if (!reset_n) begin
            for (int k = cyc - 1; k < cyc + 8 && k < N; k++) begin
                e_we[k] = 0; e_done[k] = 0; e_ill[k] = 0; e_ps[k] = 0;
            end
            m_psr = '0;
            free_at = cyc + 1;
        end else begin
            if (pre_we) m_rf[pre_idx] = pre_val;
            if (e_we[cyc-1]) m_rf[e_wa[cyc-1]] = e_wd[cyc-1];
            if (e_ps[cyc]) m_psr = e_pv[cyc];
            if (op_valid && cyc >= free_at && cyc + 4 < N) begin
                if (op_code[2:0] > 3'd3) begin
                    e_ill[cyc] = 1;
                    free_at = cyc + 1;
                end else begin
                    ma = m_rf[op_rdest];
                    mb = op_imm_sel ? op_imm : m_rf[op_rsrc];
                    alu_f(ma, mb, op_code, mr, mf);
                    e_done[cyc+2] = 1;
                    e_we[cyc+2] = op_wb_en;
                    e_wa[cyc+2] = op_rdest;
                    e_wd[cyc+2] = mr;
                    if (op_setflags) begin
                        e_ps[cyc+3] = 1;
                        e_pv[cyc+3] = mf;
                    end
                    free_at = cyc + 4;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    int done_cnt = 0;
    int we_cnt = 0;
    int ill_cnt = 0;

    // Per-cycle comparison of DUT outputs against the model schedule
    always @(negedge clk) begin
        if (reset_n && cyc > 0 && cyc < N) begin
            check("ready", 32'(op_ready), 32'(cyc + 1 >= free_at));
            check("rf_we", 32'(rf_we), 32'(e_we[cyc]));
            check("done", 32'(op_done), 32'(e_done[cyc]));
            check("illegal", 32'(op_illegal), 32'(e_ill[cyc]));
            check("psr", 32'(psr), 32'(m_psr));
            if (e_we[cyc]) begin
                check("waddr", 32'(rf_waddr), 32'(e_wa[cyc]));
                check("wdata", 32'(rf_wdata), 32'(e_wd[cyc]));
            end
            if (op_done) done_cnt++;
            if (rf_we) we_cnt++;
            if (op_illegal) ill_cnt++;
        end
    end

    task automatic preload(input logic [3:0] i, input logic [15:0] v);
        pre_idx = i;
        pre_val = v;
        pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic send(input logic [4:0] code, input logic [3:0] rd,
                        input logic [3:0] rs, input logic isel,
                        input logic [15:0] imm, input logic wb,
                        input logic sf, input bit hold);
        int n;
        op_code = code;
        op_rdest = rd;
        op_rsrc = rs;
        op_imm_sel = isel;
        op_imm = imm;
        op_wb_en = wb;
        op_setflags = sf;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!op_ready) begin
            chk_cnt++;
            $display("FAIL send_timeout: op_ready low for %0d cycles, required high", n);
        end
        @(posedge clk); #1;
        if (!hold) op_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    int d0, w0, i0, h0;

    initial begin
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk); #1;
        check("rst_psr", 32'(psr), 32'h0);
        check("rst_ready", 32'(op_ready), 32'h1);
        check("rst_we", 32'(rf_we), 32'h0);

        preload(1, 16'h0005);
        preload(2, 16'h0003);
        send(5'b00000, 1, 2, 0, 16'h0, 1, 1, 0);
        settle();
        check("t1_r1", 32'(rf[1]), 32'h0008);
        check("t1_psr", 32'(psr), 32'b00010);

        preload(1, 16'h7FFF);
        preload(2, 16'h0001);
        send(5'b01000, 1, 2, 0, 16'h0, 1, 1, 0);
        settle();
        check("t2_r1", 32'(rf[1]), 32'h8000);
        check("t2_psr", 32'(psr), 32'b10100);

        preload(4, 16'h0004);
        preload(5, 16'h0004);
        d0 = done_cnt; w0 = we_cnt;
        send(5'b11000, 4, 5, 0, 16'h0, 0, 1, 0);
        settle();
        check("t3_psr", 32'(psr), 32'b01000);
        check("t3_done", 32'(done_cnt - d0), 32'd1);
        check("t3_we", 32'(we_cnt - w0), 32'd0);
        check("t3_r4", 32'(rf[4]), 32'h0004);

        preload(2, 16'h00F0);
        send(5'b00001, 2, 0, 1, 16'h0F0F, 1, 0, 0);
        settle();
        check("t4_r2", 32'(rf[2]), 32'h0000);
        check("t4_psr", 32'(psr), 32'b01000);

        d0 = done_cnt; w0 = we_cnt; i0 = ill_cnt;
        send(5'b00100, 1, 2, 0, 16'h0, 1, 1, 0);
        check("t5_ready", 32'(op_ready), 32'h1);
        settle();
        check("t5_ill", 32'(ill_cnt - i0), 32'd1);
        check("t5_done", 32'(done_cnt - d0), 32'd0);
        check("t5_we", 32'(we_cnt - w0), 32'd0);
        check("t5_psr", 32'(psr), 32'b01000);

        preload(3, 16'h0010);
        h0 = hs.size();
        send(5'b10000, 3, 4, 0, 16'h0, 1, 1, 1);
        send(5'b00010, 3, 0, 1, 16'h0003, 1, 0, 0);
        settle();
        if (hs.size() >= h0 + 2) begin
            check("t6_gap", 32'(hs[h0+1] - hs[h0]), 32'd4);
        end else begin
            chk_cnt++;
            $display("FAIL t6_gap: saw %0d transfers, required 2", hs.size() - h0);
        end
        check("t6_r3", 32'(rf[3]), 32'h000F);
        check("t6_psr", 32'(psr), 32'b00010);

        w0 = we_cnt;
        send(5'b00000, 5, 0, 1, 16'h0100, 1, 1, 0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        settle();
        check("t7_we", 32'(we_cnt - w0), 32'd0);
        check("t7_r5", 32'(rf[5]), 32'h0004);
        check("t7_psr", 32'(psr), 32'h0);
        check("t7_ready", 32'(op_ready), 32'h1);

        send(5'b00000, 5, 0, 1, 16'h0001, 1, 0, 0);
        settle();
        check("t8_r5", 32'(rf[5]), 32'h0005);
        check("t8_psr", 32'(psr), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
